// File: rtl/ram_arbiter.sv
// Round-robin controller sharing one synchronous single-port RAM between an
// instruction-fetch requester (m0) and a load/store requester (m1).
module ram_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic                  m0_req_we,
    input  logic [ADDR_WIDTH-1:0] m0_req_addr,
    input  logic [DATA_WIDTH-1:0] m0_req_wdata,
    output logic                  m0_resp_valid,
    output logic [DATA_WIDTH-1:0] m0_resp_rdata,

    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic                  m1_req_we,
    input  logic [ADDR_WIDTH-1:0] m1_req_addr,
    input  logic [DATA_WIDTH-1:0] m1_req_wdata,
    output logic                  m1_resp_valid,
    output logic [DATA_WIDTH-1:0] m1_resp_rdata,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  last_grant;
    logic                  grant_id;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] m0_rdata_q;
    logic [DATA_WIDTH-1:0] m1_rdata_q;

    logic accept_window;
    logic pick_m1;
    logic accept;
    logic in_access;

    // Arbitration: on a tie the requester not granted last wins; ready is
    // suppressed while rst is high so no accept coincides with a reset.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        accept_window = ((state == ST_IDLE) || (state == ST_RESP)) && !rst;
        if (m0_req_valid && m1_req_valid) begin
            pick_m1 = ~last_grant;
        end else begin
            pick_m1 = m1_req_valid;
        end
        m0_req_ready = accept_window && m0_req_valid && !pick_m1;
        m1_req_ready = accept_window && pick_m1;
        accept       = m0_req_ready || m1_req_ready;
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:   state_nxt = accept ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = accept ? ST_ACCESS : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign in_access = (state == ST_ACCESS);

    // A reset during ACCESS cannot cancel the RAM write: the RAM samples
    // cs/we decoded from the pre-reset state at that same edge.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all registered state, so every flop sees pre-edge values.
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                grant_id   <= m1_req_ready;
                last_grant <= m1_req_ready;
                lat_we     <= m1_req_ready ? m1_req_we    : m0_req_we;
                lat_addr   <= m1_req_ready ? m1_req_addr  : m0_req_addr;
                lat_wdata  <= m1_req_ready ? m1_req_wdata : m0_req_wdata;
            end
            if (in_access && !lat_we) begin
                if (grant_id) begin
                    m1_rdata_q <= ram_data;
                end else begin
                    m0_rdata_q <= ram_data;
                end
            end
        end
    end

    always_comb begin
        ram_cs        = in_access;
        ram_we        = in_access && lat_we;
        ram_oe        = in_access && !lat_we;
        ram_addr      = in_access ? lat_addr : '0;
        m0_resp_valid = (state == ST_RESP) && !grant_id;
        m1_resp_valid = (state == ST_RESP) && grant_id;
    end

    assign m0_resp_rdata = m0_rdata_q;
    assign m1_resp_rdata = m1_rdata_q;

    assign ram_data = ram_we ? lat_wdata : {DATA_WIDTH{1'bz}};

endmodule
